// File: rtl/camera_window_capture_pkg.sv
// camera_window_capture_pkg: shared FSM states, decimation codes and quad-decimation helpers
package camera_window_capture_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_FINISH} state_t;
   localparam logic [1:0] DEC_1 = 2'd0, DEC_2 = 2'd1, DEC_4 = 2'd2, DEC_RSV = 2'd3;
   // q is the 2x2-quad index (offset >> 1); keep quads whose index is a multiple of D
   function automatic logic quad_keep(input logic [1:0] dec, input logic [1:0] q);
      return (dec == DEC_1 || dec == DEC_RSV) ? 1'b1 : dec == DEC_2 ? !q[0] : !(|q);
   endfunction
   // distance from the right pixel of a kept quad to the left pixel of the next kept quad
   function automatic logic [2:0] quad_step(input logic [1:0] dec);
      return (dec == DEC_1 || dec == DEC_RSV) ? 3'd1 : dec == DEC_2 ? 3'd3 : 3'd7;
   endfunction
endpackage

// File: rtl/camera_window_gate.sv
// camera_window_gate: sensor x/y counters plus window and decimation keep/end-of-line logic
module camera_window_gate
   import camera_window_capture_pkg::*;
#(parameter int CW = 12) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          line_valid,
   input  logic          frame_valid,
   input  logic          load,
   input  logic          enable,
   input  logic [CW-1:0] x_start,
   input  logic [CW-1:0] y_start,
   input  logic [CW-1:0] width,
   input  logic [CW-1:0] height,
   input  logic [1:0]    decim,
   output logic          keep,
   output logic          eol,
   output logic          lv_fall,
   output logic          fv_rise,
   output logic          fv_fall
);
   logic lv_d, fv_d, unused_lsb;
   logic [CW:0] sx, sy, xs, ys, xe, ye, nx;
   logic [CW-1:1] xs_q, ys_q, w_q, h_q;
   logic [1:0] dec_q, dec;
   logic [2:0] ox, oy;
   // the frame's first pixel can arrive on the load cycle, so bypass the latch then
   assign xs = {1'b0, load ? x_start[CW-1:1] : xs_q, 1'b0};
   assign ys = {1'b0, load ? y_start[CW-1:1] : ys_q, 1'b0};
   assign xe = xs + {1'b0, load ? width[CW-1:1] : w_q, 1'b0};
   assign ye = ys + {1'b0, load ? height[CW-1:1] : h_q, 1'b0};
   assign dec = load ? decim : dec_q;
   assign ox = sx[2:0] - xs[2:0];
   assign oy = sy[2:0] - ys[2:0];
   assign nx = sx + {{(CW-2){1'b0}}, ox[0] ? quad_step(dec) : 3'd1};
   assign keep = enable && line_valid && !sx[CW] && !sy[CW] && sx >= xs && sx < xe &&
                 sy >= ys && sy < ye && quad_keep(dec, ox[2:1]) && quad_keep(dec, oy[2:1]);
   assign eol = nx[CW] || nx >= xe;
   assign lv_fall = lv_d && !line_valid;
   assign fv_rise = frame_valid && !fv_d;
   assign fv_fall = fv_d && !frame_valid;
   assign unused_lsb = ^{x_start[0], y_start[0], width[0], height[0]};
   // counters saturate at 2^CW so an oversize line or frame never wraps back into the window
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         lv_d <= 1'b0;
         fv_d <= 1'b0;
         sx <= '0;
         sy <= '0;
         xs_q <= '0;
         ys_q <= '0;
         w_q <= '0;
         h_q <= '0;
         dec_q <= DEC_1;
      end else begin
         lv_d <= line_valid;
         fv_d <= frame_valid;
         sx <= line_valid ? sx + {{CW{1'b0}}, !sx[CW]} : '0;
         sy <= !frame_valid ? '0 : sy + {{CW{1'b0}}, lv_fall && !sy[CW]};
         if (load) begin
            xs_q <= x_start[CW-1:1];
            ys_q <= y_start[CW-1:1];
            w_q <= width[CW-1:1];
            h_q <= height[CW-1:1];
            dec_q <= decim;
         end
      end
endmodule

// File: rtl/camera_window_capture.sv
// camera_window_capture: frame-burst capture FSM and registered windowed pixel output
module camera_window_capture
   import camera_window_capture_pkg::*;
#(parameter int N = 8, parameter int CW = 12, parameter int FW = 8) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          in_start,
   input  logic          in_stop,
   input  logic [FW-1:0] in_frames,
   input  logic [CW-1:0] in_x_start,
   input  logic [CW-1:0] in_y_start,
   input  logic [CW-1:0] in_width,
   input  logic [CW-1:0] in_height,
   input  logic [1:0]    in_decim,
   input  logic          in_line_valid,
   input  logic          in_frame_valid,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   output logic [N-1:0]  out_data,
   output logic [CW-1:0] out_x,
   output logic [CW-1:0] out_y,
   output logic          out_sof,
   output logic          out_eol,
   output logic          out_captured,
   output logic          out_busy,
   output logic [FW-1:0] out_frame_count
);
   state_t state;
   logic start_d, stop_d, stop_seen, line_has;
   logic start_rise, stop_rise, load, active, keep, eol, lv_fall, fv_rise, fv_fall;
   logic [CW-1:0] x_cnt, y_cnt;
   assign start_rise = in_start && !start_d;
   assign stop_rise = in_stop && !stop_d;
   assign load = state == S_ARMED && fv_rise && !stop_rise;
   assign active = load || state == S_CAPTURE;
   assign out_busy = state != S_IDLE;
   camera_window_gate #(.CW(CW)) gate (
      .clock(clock), .reset_n(reset_n), .line_valid(in_line_valid), .frame_valid(in_frame_valid),
      .load(load), .enable(active), .x_start(in_x_start), .y_start(in_y_start), .width(in_width),
      .height(in_height), .decim(in_decim), .keep(keep), .eol(eol), .lv_fall(lv_fall),
      .fv_rise(fv_rise), .fv_fall(fv_fall)
   );
   // burst FSM; edge detectors reset high so a level held through reset is not an edge
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= S_IDLE;
         start_d <= 1'b1;
         stop_d <= 1'b1;
         stop_seen <= 1'b0;
         out_captured <= 1'b0;
         out_frame_count <= '0;
      end else begin
         start_d <= in_start;
         stop_d <= in_stop;
         out_captured <= 1'b0;
         case (state)
            S_IDLE: if (start_rise) begin
               state <= S_ARMED;
               out_frame_count <= '0;
               stop_seen <= 1'b0;
            end
            S_ARMED: state <= stop_rise ? S_IDLE : fv_rise ? S_CAPTURE : S_ARMED;
            S_CAPTURE: begin
               if (stop_rise) stop_seen <= 1'b1;
               if (fv_fall) begin
                  state <= S_FINISH;
                  out_captured <= 1'b1;
                  out_frame_count <= out_frame_count + 1'b1;
               end
            end
            default: state <= (stop_seen || stop_rise || (in_frames != '0 && out_frame_count == in_frames))
                              ? S_IDLE : S_ARMED;
         endcase
      end
   // output register and output-image coordinates; coordinates restart outside a captured frame
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_x <= '0;
         out_y <= '0;
         out_sof <= 1'b0;
         out_eol <= 1'b0;
         x_cnt <= '0;
         y_cnt <= '0;
         line_has <= 1'b0;
      end else begin
         out_valid <= keep;
         out_sof <= keep && x_cnt == '0 && y_cnt == '0;
         out_eol <= keep && eol;
         if (keep) begin
            out_data <= in_data;
            out_x <= x_cnt;
            out_y <= y_cnt;
         end
         x_cnt <= (!active || lv_fall) ? '0 : x_cnt + {{(CW-1){1'b0}}, keep};
         y_cnt <= !active ? '0 : y_cnt + {{(CW-1){1'b0}}, lv_fall && line_has};
         line_has <= active && !lv_fall && (line_has || keep);
      end
endmodule

// File: tb/tb_camera_window_capture.sv
// tb_camera_window_capture: scoreboard bench for windowed burst capture
module tb_camera_window_capture;
   localparam int N = 8, CW = 12, FW = 8;
   logic clock = 1'b0, reset_n = 1'b0, in_start = 1'b0, in_stop = 1'b0;
   logic in_line_valid = 1'b0, in_frame_valid = 1'b0;
   logic [FW-1:0] in_frames = '0;
   logic [CW-1:0] in_x_start = '0, in_y_start = '0, in_width = '0, in_height = '0;
   logic [1:0] in_decim = '0;
   logic [N-1:0] in_data = '0;
   logic out_valid, out_sof, out_eol, out_captured, out_busy;
   logic [N-1:0] out_data;
   logic [CW-1:0] out_x, out_y;
   logic [FW-1:0] out_frame_count;
   typedef struct packed {
      logic [N-1:0] d;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic sof;
      logic eol;
   } px_t;
   px_t sb[$];
   px_t got, want;
   int xl[$], yl[$];
   int checks = 0, errors = 0, caps = 0, c0;
   logic prev_lv = 1'b0;
   logic [N-1:0] prev_d = '0;

   always #5 clock = ~clock;

   camera_window_capture #(.N(N), .CW(CW), .FW(FW)) dut (
      .clock(clock), .reset_n(reset_n), .in_start(in_start), .in_stop(in_stop), .in_frames(in_frames),
      .in_x_start(in_x_start), .in_y_start(in_y_start), .in_width(in_width), .in_height(in_height),
      .in_decim(in_decim), .in_line_valid(in_line_valid), .in_frame_valid(in_frame_valid),
      .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
      .out_sof(out_sof), .out_eol(out_eol), .out_captured(out_captured), .out_busy(out_busy),
      .out_frame_count(out_frame_count)
   );

   function automatic logic [N-1:0] pix(input int x, input int y);
      return N'((x * 7 + y * 13) & 255);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", n, a, e);
      end
   endtask

   task automatic set_win(input int x, input int y, input int w, input int h, input int d);
      in_x_start = CW'(x);
      in_y_start = CW'(y);
      in_width = CW'(w);
      in_height = CW'(h);
      in_decim = 2'(d);
   endtask

   task automatic push_exp();
      px_t p;
      foreach (yl[j])
         foreach (xl[i]) begin
            p.d = pix(xl[i], yl[j]);
            p.x = CW'(i);
            p.y = CW'(j);
            p.sof = i == 0 && j == 0;
            p.eol = i == xl.size() - 1;
            sb.push_back(p);
         end
   endtask

   task automatic arm();
      in_start = 1'b1;
      tick();
      tick();
      in_start = 1'b0;
      tick();
   endtask

   task automatic frame(input int w, input int h, input int start_line, input int stop_line);
      in_frame_valid = 1'b1;
      tick();
      tick();
      for (int y = 0; y < h; y++) begin
         if (y == start_line) in_start = 1'b1;
         if (y == stop_line) in_stop = 1'b1;
         for (int x = 0; x < w; x++) begin
            in_line_valid = 1'b1;
            in_data = pix(x, y);
            tick();
         end
         in_line_valid = 1'b0;
         in_data = '0;
         repeat (3) tick();
      end
      in_frame_valid = 1'b0;
      in_start = 1'b0;
      in_stop = 1'b0;
      repeat (6) tick();
   endtask

   task automatic wait_idle(input string n);
      for (int i = 0; i < 50 && out_busy; i++) tick();
      chk({n, "_idle"}, 32'(out_busy), 0);
      chk({n, "_drain"}, sb.size(), 0);
   endtask

   task automatic rng(input int a, input int b, output int q[$]);
      q.delete();
      for (int i = a; i <= b; i++) q.push_back(i);
   endtask

   // monitor: every output pixel is popped from the scoreboard and must echo the previous cycle's input
   always @(negedge clock) begin
      if (out_captured) caps++;
      if (out_valid) begin
         checks++;
         got = {out_data, out_x, out_y, out_sof, out_eol};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel: got d=%0h x=%0d y=%0d, required no pixel", out_data, out_x, out_y);
         end else begin
            want = sb.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL pixel: got d=%0h x=%0d y=%0d sof=%0b eol=%0b, required d=%0h x=%0d y=%0d sof=%0b eol=%0b",
                        got.d, got.x, got.y, got.sof, got.eol, want.d, want.x, want.y, want.sof, want.eol);
            end
         end
         checks++;
         if (!prev_lv || out_data !== prev_d) begin
            errors++;
            $display("FAIL latency: got d=%0h, required d=%0h sampled one cycle earlier", out_data, prev_d);
         end
      end
      prev_lv = in_line_valid;
      prev_d = in_data;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_busy", 32'(out_busy), 0);
      chk("reset_count", 32'(out_frame_count), 0);
      chk("reset_captured", 32'(out_captured), 0);
      // window (4,2) 8x4, D=1, one frame
      set_win(4, 2, 8, 4, 0);
      in_frames = 1;
      rng(4, 11, xl);
      rng(2, 5, yl);
      push_exp();
      c0 = caps;
      arm();
      chk("A_busy", 32'(out_busy), 1);
      frame(16, 8, -1, -1);
      wait_idle("A");
      chk("A_caps", caps - c0, 1);
      chk("A_count", 32'(out_frame_count), 1);
      // full sensor, D=2: keep quads 0,2,4,6 in x and 0,2 in y
      set_win(0, 0, 16, 8, 1);
      xl = {0, 1, 4, 5, 8, 9, 12, 13};
      yl = {0, 1, 4, 5};
      push_exp();
      c0 = caps;
      arm();
      frame(16, 8, -1, -1);
      wait_idle("B");
      chk("B_caps", caps - c0, 1);
      // arm during an active frame; that frame is skipped, then 3 frames
      set_win(4, 2, 8, 4, 0);
      in_frames = 3;
      rng(4, 11, xl);
      rng(2, 5, yl);
      c0 = caps;
      frame(16, 8, 1, -1);
      chk("C_armed", 32'(out_busy), 1);
      chk("C_skip_caps", caps - c0, 0);
      repeat (3) begin
         push_exp();
         frame(16, 8, -1, -1);
      end
      wait_idle("C");
      chk("C_caps", caps - c0, 3);
      chk("C_count", 32'(out_frame_count), 3);
      // continuous mode, stop during frame 5
      set_win(0, 0, 2, 2, 0);
      in_frames = 0;
      rng(0, 1, xl);
      rng(0, 1, yl);
      c0 = caps;
      arm();
      for (int f = 0; f < 4; f++) begin
         push_exp();
         frame(16, 8, -1, -1);
      end
      chk("D_still_busy", 32'(out_busy), 1);
      push_exp();
      frame(16, 8, -1, 2);
      wait_idle("D");
      chk("D_caps", caps - c0, 5);
      chk("D_count", 32'(out_frame_count), 5);
      // zero width: no pixels, frame still counted
      set_win(0, 0, 0, 8, 0);
      in_frames = 1;
      c0 = caps;
      arm();
      frame(16, 8, -1, -1);
      wait_idle("W");
      chk("W_caps", caps - c0, 1);
      chk("W_count", 32'(out_frame_count), 1);
      // window running past the sensor edge is clipped, no wrap to sx 0
      set_win(4090, 0, 16, 2, 0);
      rng(4090, 4095, xl);
      rng(0, 1, yl);
      push_exp();
      c0 = caps;
      arm();
      frame(4100, 2, -1, -1);
      wait_idle("F");
      chk("F_caps", caps - c0, 1);
      // reset in mid-frame with in_start held high through release
      set_win(4, 2, 8, 4, 0);
      arm();
      in_frame_valid = 1'b1;
      tick();
      tick();
      in_line_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = pix(i, 0);
         tick();
      end
      in_start = 1'b1;
      reset_n = 1'b0;
      #2;
      chk("E_busy", 32'(out_busy), 0);
      chk("E_valid", 32'(out_valid), 0);
      chk("E_data", 32'(out_data), 0);
      chk("E_count", 32'(out_frame_count), 0);
      in_line_valid = 1'b0;
      in_frame_valid = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      c0 = caps;
      frame(16, 8, -1, -1);
      chk("E_no_arm", 32'(out_busy), 0);
      chk("E_caps", caps - c0, 0);
      chk("E_drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
